// File: rtl/svlog_frame_rx.sv
// svlog_frame_rx: receives A, B, CRC-8 byte frames and presents them with CRC status.
// Stalled partial frames are aborted after TIMEOUT idle cycles.
module svlog_frame_rx #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_a,
    output logic [7:0]  out_b,
    output logic        crc_ok,
    output logic        timeout,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, GET_B, GET_CRC, DELIVER} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_crc, r_idle, r_a, r_b, w_crc_next;
    logic        w_in_xfer, w_out_xfer, w_waiting, w_abort;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
        return c;
    endfunction

    assign w_crc_next = crc8_byte(r_crc, in_data);

    always_comb begin
        w_next     = r_state;
        in_ready   = r_state != DELIVER;
        out_valid  = r_state == DELIVER;
        w_in_xfer  = in_valid && in_ready;
        w_out_xfer = out_valid && out_ready;
        w_waiting  = r_state == GET_B || r_state == GET_CRC;
        // a transfer on the threshold cycle wins over the abort
        w_abort    = w_waiting && !w_in_xfer && r_idle == 8'(TIMEOUT - 1);
        case (r_state)
            IDLE:    w_next = w_in_xfer ? GET_B : IDLE;
            GET_B:   w_next = w_in_xfer ? GET_CRC : GET_B;
            GET_CRC: w_next = w_in_xfer ? DELIVER : GET_CRC;
            DELIVER: w_next = w_out_xfer ? IDLE : DELIVER;
            default: w_next = IDLE;
        endcase
        if (w_abort)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc     <= 8'h00;
            r_idle    <= 8'h00;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            out_a     <= 8'h00;
            out_b     <= 8'h00;
            crc_ok    <= 1'b0;
            timeout   <= 1'b0;
            frame_cnt <= 16'h0000;
            err_cnt   <= 8'h00;
        end else begin
            timeout <= w_abort;
            if (w_abort || w_out_xfer) begin
                r_crc  <= 8'h00;
                r_idle <= 8'h00;
            end else if (w_in_xfer) begin
                r_idle <= 8'h00;
                case (r_state)
                    IDLE: begin
                        r_a   <= in_data;
                        r_crc <= w_crc_next;
                    end
                    GET_B: begin
                        r_b   <= in_data;
                        r_crc <= w_crc_next;
                    end
                    GET_CRC: begin
                        out_a  <= r_a;
                        out_b  <= r_b;
                        crc_ok <= in_data == r_crc;
                    end
                    default: ;
                endcase
            end else if (w_waiting) begin
                r_idle <= r_idle + 8'h01;
            end
            if (w_out_xfer) begin
                frame_cnt <= frame_cnt + 16'h0001;
                if (!crc_ok && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'h01;
            end
        end
    end
endmodule

// File: doc/svlog_frame_rx.md
SVLOG_FRAME_RX -- requirements
Module: svlog_frame_rx

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of idle mid-frame cycles before the current frame is aborted; legal range is 2..255.
REQ-002 clk  input  1  is the single clock; all logic is rising-edge.
REQ-003 rst  input  1  is a synchronous, active-high reset.
REQ-004 in_valid  input  1  means in_data holds a valid byte.
REQ-005 in_data  input  8  is the frame byte.
REQ-006 in_ready  output  1  means the block accepts a byte; a byte transfers on a cycle with in_valid & in_ready.
REQ-007 out_valid  output  1  means a received frame is presented.
REQ-008 out_ready  input  1  means the sink accepts the frame; the frame transfers on a cycle with out_valid & out_ready.
REQ-009 out_a  output  8  is the first payload byte (A).
REQ-010 out_b  output  8  is the second payload byte (B).
REQ-011 crc_ok  output  1  means the received CRC matched; it is valid only while out_valid is high.
REQ-012 timeout  output  1  is a one-cycle pulse on frame abort.
REQ-013 frame_cnt  output  16  counts delivered frames.
REQ-014 err_cnt  output  8  counts delivered frames with a CRC mismatch.

Function
REQ-015 Frame format shall be three bytes in this order: A, B, CRC; this is the receive side of the push-A / push-B / CRC transmitter.
REQ-016 CRC shall be CRC-8: polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR, computed over A then B.
REQ-017 FSM shall have four states:
  - IDLE: wait for A.
  - GET_B: wait for B.
  - GET_CRC: wait for the CRC byte.
  - DELIVER: present the frame.
REQ-018 Transitions shall be:
  - IDLE -> GET_B on an A transfer.
  - GET_B -> GET_CRC on a B transfer.
  - GET_CRC -> DELIVER on a CRC transfer.
  - DELIVER -> IDLE on an output transfer.
  - Otherwise the state holds.
REQ-019 in_ready shall be 1 in IDLE, GET_B and GET_CRC, and 0 in DELIVER; it shall be a registered-state decode with no combinational path from out_ready.
REQ-020 out_valid shall be 1 exactly in DELIVER, rising the cycle after the CRC byte transfers (latency 1 cycle).
REQ-021 out_a, out_b and crc_ok shall stay stable while out_valid=1 and out_ready=0.
REQ-022 crc_ok shall equal (received CRC byte == running CRC over A,B), registered on the CRC transfer.
REQ-023 A frame with a bad CRC shall still be delivered, with crc_ok=0.
REQ-024 frame_cnt shall increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-025 err_cnt shall increment on each output transfer with crc_ok=0 and saturate at 0xFF.
REQ-026 Idle counter behaviour in GET_B and GET_CRC:
  - Counts consecutive cycles without a byte transfer.
  - Clears on every transfer and on entry to GET_B.
  - On reaching TIMEOUT: return to IDLE, pulse timeout for 1 cycle, clear the running CRC, discard the partial frame, leave the counters unchanged.
REQ-027 A byte transfer and the timeout threshold in the same cycle shall resolve in favour of the transfer, with no timeout.
REQ-028 There shall be no timeout in IDLE or DELIVER; DELIVER waits indefinitely for out_ready.
REQ-029 in_data shall be ignored whenever in_valid=0 or in_ready=0.
REQ-030 The running CRC shall reset to 0x00 on entry to IDLE.

Reset
REQ-031 While rst=1 at a clock edge, all outputs shall take these values:
  - state=IDLE, running CRC=0x00, idle counter=0.
  - out_valid=0, in_ready=1 (from the cycle after reset).
  - out_a=0x00, out_b=0x00, crc_ok=0, timeout=0.
  - frame_cnt=0, err_cnt=0.
REQ-032 Reset asserted mid-frame or during DELIVER shall abandon the frame with no delivery, no timeout pulse, and no counter update.

Verification
REQ-033 Send 0x01, 0x02, 0x1B back-to-back with out_ready=1 -> out_valid=1 one cycle after the CRC byte, out_a=0x01, out_b=0x02, crc_ok=1, frame_cnt=1, err_cnt=0.
REQ-034 Send 0x00, 0x00, 0x55 -> crc_ok=0, err_cnt=1, frame delivered.
REQ-035 Hold out_ready=0 for 5 cycles after a frame -> in_ready=0 and outputs stable throughout; out_ready=1 -> one transfer, then IDLE with in_ready=1.
REQ-036 Send A only, then in_valid=0 for TIMEOUT cycles -> one timeout pulse, then IDLE; next frame 0x01, 0x02, 0x1B decodes with crc_ok=1.
REQ-037 Drive a byte transfer on the exact timeout cycle -> no timeout, FSM advances.
REQ-038 Force 256 bad-CRC frames -> err_cnt stays at 0xFF and frame_cnt=256; assert rst mid-frame -> all outputs return to their reset values.
